// File: rtl/ps2_scancode_sequencer.sv
// PS/2 set-2 scan-code sequencer: merges E0/F0 prefixes into make/break events queued in a FWFT FIFO.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress repeated arrow make events while the key is held.
module ps2_scancode_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_error,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [3:0] held_arrows,
  output logic       overflow,
  output logic       proto_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic            err_now;
  logic            dec, dec_ext, dec_brk;
  logic            silent;
  logic [3:0]      arrow_mask;
  logic [3:0]      held_nxt;
  logic            suppress;
  logic            push;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, wr_en;
  logic [9:0]      head;

  always_comb begin
    silent = 1'b0;
    case (byte_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: silent = 1'b1;
      default: silent = 1'b0;
    endcase
  end

  always_comb begin
    arrow_mask = 4'b0000;
    case (byte_data)
      8'h75: arrow_mask = 4'b1000;
      8'h72: arrow_mask = 4'b0100;
      8'h6B: arrow_mask = 4'b0010;
      8'h74: arrow_mask = 4'b0001;
      default: arrow_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    err_now   = 1'b0;
    dec       = 1'b0;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    if (byte_valid) begin
      tmo_nxt = '0;
      if (byte_error) begin
        state_nxt = IDLE;
        err_now   = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (byte_data == 8'hE0)      state_nxt = EXT;
            else if (byte_data == 8'hF0) state_nxt = BRK;
            else if (!silent)            dec = 1'b1;
          end
          EXT: begin
            if (byte_data == 8'hF0) state_nxt = EXT_BRK;
            else if (byte_data != 8'hE0) begin
              dec       = 1'b1;
              dec_ext   = 1'b1;
              state_nxt = IDLE;
            end
          end
          BRK, EXT_BRK: begin
            state_nxt = IDLE;
            if (byte_data == 8'hE0 || byte_data == 8'hF0) begin
              err_now = 1'b1;
            end else begin
              dec     = 1'b1;
              dec_brk = 1'b1;
              dec_ext = (state == EXT_BRK);
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (tmo == TW'(TIMEOUT - 1)) begin
        state_nxt = IDLE;
        err_now   = 1'b1;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo + 1'b1;
      end
    end
  end

  // Held bitmap tracks every decoded arrow event, even ones later filtered or dropped at a full FIFO.
  always_comb begin
    held_nxt = held_arrows;
    if (dec && dec_ext) begin
      if (dec_brk) held_nxt = held_arrows & ~arrow_mask;
      else         held_nxt = held_arrows | arrow_mask;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = dec && dec_ext && !dec_brk && ((held_arrows & arrow_mask) != 4'b0000);
`else
  assign suppress = 1'b0;
`endif

  assign push  = dec && !suppress;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = evt_valid && evt_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      tmo         <= '0;
      proto_err   <= 1'b0;
      held_arrows <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      tmo         <= tmo_nxt;
      proto_err   <= err_now;
      held_arrows <= held_nxt;
      if (push && full && !pop) overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {dec_ext, dec_brk, byte_data};
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? head[7:0] : '0;
  assign evt_break = evt_valid & head[8];
  assign evt_ext   = evt_valid & head[9];

endmodule
